// File: rtl/casex_match_pkg.sv
// Shared types and the masked-compare rule for the casex match sequencer.
// Optional key mask: CASEX_MATCH_KEY_MASK_EN (used by the cmp, if and top files).
package casex_match_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Compare operands are zero-extended to this width; WIDTH must not exceed it.
    localparam int CMP_MAX_W = 32;

    function automatic logic mask_match(input logic [CMP_MAX_W-1:0] key,
                                        input logic [CMP_MAX_W-1:0] pat,
                                        input logic [CMP_MAX_W-1:0] care);
        return ((key ^ pat) & care) == '0;
    endfunction

endpackage

// File: rtl/casex_match_sequencer_if.sv
// Config, request and response bundle for casex_match_sequencer.
// req_care exists only when CASEX_MATCH_KEY_MASK_EN is defined.
interface casex_match_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              cfg_valid;
    logic              cfg_ready;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_en;
    logic [WIDTH-1:0]  cfg_pat;
    logic [WIDTH-1:0]  cfg_care;
    logic [DATA_W-1:0] cfg_data;
    logic [DATA_W-1:0] cfg_default;

    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_key;
`ifdef CASEX_MATCH_KEY_MASK_EN
    logic [WIDTH-1:0]  req_care;
`endif

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [IDX_W-1:0]  rsp_idx;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cfg_valid, cfg_idx, cfg_en, cfg_pat, cfg_care, cfg_data, cfg_default,
        output req_valid, req_key,
`ifdef CASEX_MATCH_KEY_MASK_EN
        output req_care,
`endif
        output rsp_ready,
        input  cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_data
    );

    modport slave (
        input  cfg_valid, cfg_idx, cfg_en, cfg_pat, cfg_care, cfg_data, cfg_default,
        input  req_valid, req_key,
`ifdef CASEX_MATCH_KEY_MASK_EN
        input  req_care,
`endif
        input  rsp_ready,
        output cfg_ready, req_ready, rsp_valid, rsp_hit, rsp_idx, rsp_data
    );

endinterface

// File: rtl/casex_match_cmp.sv
// Single-entry don't-care compare: hit when enabled and all cared bits agree.
// With CASEX_MATCH_KEY_MASK_EN, key bits cleared in req_care_i also match anything.
module casex_match_cmp
    import casex_match_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] key_i,
    input  logic [WIDTH-1:0] pat_i,
    input  logic [WIDTH-1:0] care_i,
`ifdef CASEX_MATCH_KEY_MASK_EN
    input  logic [WIDTH-1:0] req_care_i,
`endif
    input  logic             en_i,
    output logic             hit_o
);

    logic [CMP_MAX_W-1:0] key_w;
    logic [CMP_MAX_W-1:0] pat_w;
    logic [CMP_MAX_W-1:0] care_w;

    always_comb begin
        key_w  = '0;
        pat_w  = '0;
        care_w = '0;
        key_w[WIDTH-1:0] = key_i;
        pat_w[WIDTH-1:0] = pat_i;
`ifdef CASEX_MATCH_KEY_MASK_EN
        care_w[WIDTH-1:0] = care_i & req_care_i;
`else
        care_w[WIDTH-1:0] = care_i;
`endif
    end

    assign hit_o = en_i & mask_match(key_w, pat_w, care_w);

endmodule

// File: rtl/casex_match_sequencer.sv
// Sequential first-match lookup over a DEPTH-entry pattern/care table, one entry per cycle.
// Optional per-request key mask: CASEX_MATCH_KEY_MASK_EN.
//
// state   | meaning
// IDLE    | ready for a table write or a lookup request (cfg wins)
// SCAN    | comparing entry scan_q against the latched key
// RESP    | result held on rsp_* until rsp_ready
module casex_match_sequencer
    import casex_match_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    casex_match_sequencer_if.slave  bus
);

    localparam int               IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [DEPTH-1:0]  en_q;
    logic [WIDTH-1:0]  pat_q  [DEPTH];
    logic [WIDTH-1:0]  care_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    state_e            state_q;
    logic              rdy_q;
    logic [IDX_W-1:0]  scan_q;
    logic [IDX_W-1:0]  scan_d;
    logic [WIDTH-1:0]  key_q;
`ifdef CASEX_MATCH_KEY_MASK_EN
    logic [WIDTH-1:0]  kcare_q;
`endif
    logic [DATA_W-1:0] dflt_q;

    logic              rsp_valid_q;
    logic              rsp_hit_q;
    logic [IDX_W-1:0]  rsp_idx_q;
    logic [DATA_W-1:0] rsp_data_q;

    logic cfg_fire;
    logic req_fire;
    logic hit;

    // A pending cfg write masks req_ready so a request is never seen as taken while deferred.
    assign bus.cfg_ready = rdy_q;
    assign bus.req_ready = rdy_q & ~bus.cfg_valid;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_hit   = rsp_hit_q;
    assign bus.rsp_idx   = rsp_idx_q;
    assign bus.rsp_data  = rsp_data_q;

    assign cfg_fire = bus.cfg_valid & rdy_q;
    assign req_fire = bus.req_valid & bus.req_ready;
    assign scan_d   = scan_q + 1'b1;

    casex_match_cmp #(.WIDTH(WIDTH)) u_cmp (
        .key_i      (key_q),
        .pat_i      (pat_q[scan_q]),
        .care_i     (care_q[scan_q]),
`ifdef CASEX_MATCH_KEY_MASK_EN
        .req_care_i (kcare_q),
`endif
        .en_i       (en_q[scan_q]),
        .hit_o      (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rdy_q       <= 1'b0;
            scan_q      <= '0;
            key_q       <= '0;
`ifdef CASEX_MATCH_KEY_MASK_EN
            kcare_q     <= '0;
`endif
            dflt_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_data_q  <= '0;
            en_q        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pat_q[i]  <= '0;
                care_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (cfg_fire) begin
                        en_q[bus.cfg_idx]   <= bus.cfg_en;
                        pat_q[bus.cfg_idx]  <= bus.cfg_pat;
                        care_q[bus.cfg_idx] <= bus.cfg_care;
                        data_q[bus.cfg_idx] <= bus.cfg_data;
                    end else if (req_fire) begin
                        key_q   <= bus.req_key;
`ifdef CASEX_MATCH_KEY_MASK_EN
                        kcare_q <= bus.req_care;
`endif
                        dflt_q  <= bus.cfg_default;
                        scan_q  <= '0;
                        rdy_q   <= 1'b0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (hit) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b1;
                        rsp_idx_q   <= scan_q;
                        rsp_data_q  <= data_q[scan_q];
                        state_q     <= ST_RESP;
                    end else if (scan_q == LAST_IDX) begin
                        rsp_valid_q <= 1'b1;
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_data_q  <= dflt_q;
                        state_q     <= ST_RESP;
                    end else begin
                        scan_q <= scan_d;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_hit_q   <= 1'b0;
                        rsp_idx_q   <= '0;
                        rsp_data_q  <= '0;
                        rdy_q       <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_casex_match_sequencer.sv
// Directed bench for casex_match_sequencer with a latency/first-match reference model.
// Builds with or without CASEX_MATCH_KEY_MASK_EN.
module tb_casex_match_sequencer;

    localparam int WIDTH  = 4;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    casex_match_sequencer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();

    casex_match_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
        logic [7:0] data;
        logic [4:0] lat;
    } res_t;

    logic [DEPTH-1:0] t_en;
    logic [3:0]       t_pat  [DEPTH];
    logic [3:0]       t_care [DEPTH];
    logic [7:0]       t_data [DEPTH];

    logic m_rdy, m_busy, m_vld;
    logic [4:0] m_cnt;
    res_t m_res;

    // First enabled entry whose cared bits equal the key wins; latency is its index + 1.
    function automatic res_t model_lookup(input logic [3:0] key, input logic [3:0] rc,
                                          input logic [7:0] dflt);
        res_t r;
        r.hit = 1'b0; r.idx = 3'd0; r.data = dflt; r.lat = 5'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--)
            if (t_en[i] && (((key ^ t_pat[i]) & t_care[i] & rc) == 4'd0)) begin
                r.hit = 1'b1; r.idx = 3'(i); r.data = t_data[i]; r.lat = 5'(i + 1);
            end
        return r;
    endfunction

    function automatic logic [3:0] cur_rc();
`ifdef CASEX_MATCH_KEY_MASK_EN
        return bus.req_care;
`else
        return 4'hF;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy <= 1'b0; m_busy <= 1'b0; m_vld <= 1'b0; m_cnt <= '0;
            m_res <= '0;   t_en <= '0;
        end else if (!m_busy) begin
            m_rdy <= 1'b1;
            if (m_rdy && bus.cfg_valid) begin
                t_en[bus.cfg_idx]   <= bus.cfg_en;
                t_pat[bus.cfg_idx]  <= bus.cfg_pat;
                t_care[bus.cfg_idx] <= bus.cfg_care;
                t_data[bus.cfg_idx] <= bus.cfg_data;
            end else if (m_rdy && bus.req_valid) begin
                m_res  <= model_lookup(bus.req_key, cur_rc(), bus.cfg_default);
                m_cnt  <= model_lookup(bus.req_key, cur_rc(), bus.cfg_default).lat;
                m_busy <= 1'b1;
                m_rdy  <= 1'b0;
            end
        end else if (!m_vld) begin
            if (m_cnt == 5'd1) m_vld <= 1'b1;
            m_cnt <= m_cnt - 5'd1;
        end else if (bus.rsp_ready) begin
            m_vld <= 1'b0; m_busy <= 1'b0; m_rdy <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        #1;
        chk("cfg_ready", 32'(bus.cfg_ready), 32'(m_rdy));
        chk("req_ready", 32'(bus.req_ready), 32'(m_rdy & ~bus.cfg_valid));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
        chk("rsp_hit",   32'(bus.rsp_hit),   m_vld ? 32'(m_res.hit)  : 32'd0);
        chk("rsp_idx",   32'(bus.rsp_idx),   m_vld ? 32'(m_res.idx)  : 32'd0);
        chk("rsp_data",  32'(bus.rsp_data),  m_vld ? 32'(m_res.data) : 32'd0);
    end

    // ---------------- directed stimulus ----------------
    task automatic cfg_write(input logic [2:0] idx, input logic en, input logic [3:0] pat,
                             input logic [3:0] care, input logic [7:0] data);
        int n = 0;
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_idx = idx; bus.cfg_en = en;
        bus.cfg_pat = pat; bus.cfg_care = care; bus.cfg_data = data;
        #1;
        while (!bus.cfg_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("cfg_accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
    endtask

    task automatic load_table(input logic en0);
        cfg_write(3'd0, en0,  4'b1100, 4'b1100, 8'd1);
        cfg_write(3'd1, 1'b1, 4'b0011, 4'b0011, 8'd2);
        cfg_write(3'd2, 1'b1, 4'b1010, 4'b1010, 8'd3);
        cfg_write(3'd3, 1'b1, 4'b0000, 4'b0101, 8'd4);
    endtask

    // Called on the negedge after the accepting posedge.
    task automatic wait_rsp(input logic eh, input logic [2:0] ei, input logic [7:0] ed,
                            input int elat, input int hold);
        int cyc = 0;
        chk("rsp_not_early", 32'(bus.rsp_valid), 32'd0);
        do begin
            @(posedge clk); cyc++; @(negedge clk);
        end while (!bus.rsp_valid && cyc < 20);
        chk("rsp_latency", 32'(cyc), 32'(elat));
        chk("lit_hit",  32'(bus.rsp_hit),  32'(eh));
        chk("lit_idx",  32'(bus.rsp_idx),  32'(ei));
        chk("lit_data", 32'(bus.rsp_data), 32'(ed));
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            #1;
            chk("hold_valid",   32'(bus.rsp_valid), 32'd1);
            chk("hold_data",    32'(bus.rsp_data),  32'(ed));
            chk("hold_idx",     32'(bus.rsp_idx),   32'(ei));
            chk("hold_req_rdy", 32'(bus.req_ready), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        #1;
        chk("idle_after_rsp", 32'(bus.cfg_ready), 32'd1);
        chk("rsp_cleared",    32'(bus.rsp_data),  32'd0);
    endtask

    task automatic lookup(input logic [3:0] key, input logic [7:0] dflt, input logic eh,
                          input logic [2:0] ei, input logic [7:0] ed, input int elat,
                          input int hold);
        int n = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_key = key; bus.cfg_default = dflt;
        #1;
        while (!bus.req_ready && n < 20) begin @(negedge clk); #1; n++; end
        chk("req_accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(eh, ei, ed, elat, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_valid = 0; bus.cfg_idx = 0; bus.cfg_en = 0; bus.cfg_pat = 0;
        bus.cfg_care = 0; bus.cfg_data = 0; bus.cfg_default = 0;
        bus.req_valid = 0; bus.req_key = 0; bus.rsp_ready = 0;
`ifdef CASEX_MATCH_KEY_MASK_EN
        bus.req_care = 4'hF;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("post_rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

        load_table(1'b1);
        lookup(4'b1100, 8'h00, 1'b1, 3'd0, 8'd1, 1, 0);
        lookup(4'b0111, 8'h00, 1'b1, 3'd1, 8'd2, 2, 0);
        lookup(4'b1010, 8'h00, 1'b1, 3'd2, 8'd3, 3, 0);
        lookup(4'b0000, 8'h00, 1'b1, 3'd3, 8'd4, 4, 0);
        lookup(4'b0101, 8'hEE, 1'b0, 3'd0, 8'hEE, 8, 5);

        // cfg and req together: cfg taken first, req the cycle after
        @(negedge clk);
        bus.cfg_valid = 1'b1; bus.cfg_idx = 3'd7; bus.cfg_en = 1'b0;
        bus.cfg_pat = 4'h0; bus.cfg_care = 4'h0; bus.cfg_data = 8'h77;
        bus.req_valid = 1'b1; bus.req_key = 4'b1100; bus.cfg_default = 8'h00;
        #1;
        chk("both_cfg_ready", 32'(bus.cfg_ready), 32'd1);
        chk("both_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        bus.cfg_valid = 1'b0;
        #1;
        chk("req_after_cfg", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(1'b1, 3'd0, 8'd1, 1, 0);

        // reset in the middle of a scan
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_key = 4'b0101; bus.cfg_default = 8'h33;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cfg_ready", 32'(bus.cfg_ready), 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_ready_back", 32'(bus.cfg_ready), 32'd1);
        repeat (10) @(negedge clk);
        #1;
        chk("no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
        lookup(4'b1100, 8'hA5, 1'b0, 3'd0, 8'hA5, 8, 0);

        // entry 0 disabled; with the key mask only the low two key bits are cared
        load_table(1'b0);
`ifdef CASEX_MATCH_KEY_MASK_EN
        bus.req_care = 4'b0011;
`endif
        lookup(4'b1011, 8'h55, 1'b1, 3'd1, 8'd2, 2, 0);
`ifdef CASEX_MATCH_KEY_MASK_EN
        lookup(4'b0100, 8'h55, 1'b1, 3'd3, 8'd4, 4, 0);
        bus.req_care = 4'hF;
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
